// File: rtl/vliw_divider.sv
// Iterative restoring integer divider, BITS_PER_CYCLE quotient bits per clock.
// Signed operands are divided as magnitudes, with the signs applied when the result is registered.
module vliw_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 6
) (
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_zero,
    output logic             busy
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] pr_q;
    logic [WIDTH-1:0]   div_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               sel_rem_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_dz_q;

    logic               accept;
    logic               a_neg, b_neg, b_zero, ovf;
    logic [WIDTH-1:0]   a_mag, b_mag, spec_res;
    logic [WIDTH-1:0]   q_raw, r_raw, res_d;

    assign in_ready     = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept       = in_valid && in_ready && !flush;
    assign busy         = (state_q != IDLE);
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_tag      = out_tag_q;
    assign out_div_zero = out_dz_q;

    assign a_neg  = in_signed && in_a[WIDTH-1];
    assign b_neg  = in_signed && in_b[WIDTH-1];
    assign a_mag  = a_neg ? -in_a : in_a;
    assign b_mag  = b_neg ? -in_b : in_b;
    assign b_zero = (in_b == '0);
    assign ovf    = in_signed && (in_a == MIN) && (&in_b);
    // Divide-by-zero returns the raw dividend as remainder; signed overflow gives MIN, 0.
    assign spec_res = b_zero ? (in_rem ? in_a : '1) : (in_rem ? '0 : MIN);

    // Unrolled restoring steps; upper half holds the partial remainder (< divisor),
    // quotient bits enter at the LSB end.
    logic [BITS_PER_CYCLE:0][2*WIDTH-1:0] stg;
    assign stg[0] = pr_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [WIDTH:0] hi;
        logic [WIDTH:0] diff;
        logic           ge;
        assign hi   = stg[i][2*WIDTH-1:WIDTH-1];
        assign diff = hi - {1'b0, div_q};
        assign ge   = !diff[WIDTH];
        assign stg[i+1] = {(ge ? diff[WIDTH-1:0] : hi[WIDTH-1:0]), stg[i][WIDTH-2:0], ge};
    end

    assign q_raw = stg[BITS_PER_CYCLE][WIDTH-1:0];
    assign r_raw = stg[BITS_PER_CYCLE][2*WIDTH-1:WIDTH];
    assign res_d = sel_rem_q ? (neg_r_q ? -r_raw : r_raw)
                             : (neg_q_q ? -q_raw : q_raw);

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pr_q         <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            sel_rem_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_dz_q     <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_tag_q <= in_tag;
            sel_rem_q <= in_rem;
            neg_r_q   <= a_neg;
            neg_q_q   <= a_neg ^ b_neg;
            div_q     <= b_mag;
            pr_q      <= {{WIDTH{1'b0}}, a_mag};
            cnt_q     <= CNT_W'(N);
            if (b_zero || ovf) begin
                state_q      <= DONE;
                out_valid_q  <= 1'b1;
                out_result_q <= spec_res;
                out_dz_q     <= b_zero;
            end else begin
                state_q     <= CALC;
                out_valid_q <= 1'b0;
                out_dz_q    <= 1'b0;
            end
        end else begin
            case (state_q)
                CALC: begin
                    pr_q  <= stg[BITS_PER_CYCLE];
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= res_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
